// File: rtl/mem_burst_sched_pkg.sv
// Shared constants and types for the burst read scheduler.
// Line size, response-byte width and FSM state encoding.
package mem_burst_sched_pkg;

  localparam int LINE_BYTES = 32;
  localparam int RSP_W = 6;

  typedef logic [RSP_W-1:0] rsp_bytes_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

endpackage

// File: rtl/mem_burst_sched_rr_pick.sv
// Round-robin picker: first requester at or after ptr wins.
// Purely combinational, one-hot grant out.
module mem_rr_pick #(
  parameter int N  = 6,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_burst_sched.sv
// Arbitrates client burst reads onto one SRAM line-read port.
// One burst in flight; responses trail each read by one cycle.
module mem_burst_sched #(
  parameter int NUM_CLIENTS = 6,
  parameter int ADDR_WIDTH  = 19,
  parameter int SIZE_WIDTH  = 20,
  parameter int LINE_BYTES  = mem_burst_sched_pkg::LINE_BYTES
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CLIENTS-1:0]                client_req,
  input  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] client_addr,
  input  logic [NUM_CLIENTS-1:0][SIZE_WIDTH-1:0] client_size,
  output logic [NUM_CLIENTS-1:0]                client_gnt,
  input  logic                                  sram_busy,
  output logic                                  sram_rd,
  output logic [ADDR_WIDTH-1:0]                 sram_addr,
  output logic [NUM_CLIENTS-1:0]                rsp_valid,
  output mem_burst_sched_pkg::rsp_bytes_t       rsp_bytes,
  output logic                                  rsp_last,
  output logic                                  busy
);

  import mem_burst_sched_pkg::*;

  localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int LB = $clog2(LINE_BYTES);
  localparam int CW = SIZE_WIDTH - LB + 1;

  state_t                 state;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          pick_idx;
  logic [PW-1:0]          ptr_nxt;
  logic [NUM_CLIENTS-1:0] pick;
  logic [NUM_CLIENTS-1:0] owner;
  logic [ADDR_WIDTH-1:0]  cur;
  logic [CW-1:0]          left;
  logic [CW-1:0]          lines_new;
  logic [LB-1:0]          tail;
  logic [SIZE_WIDTH-1:0]  sz;
  logic [SIZE_WIDTH:0]    sz_up;
  logic                   pend_v;
  logic                   pend_last;
  rsp_bytes_t             pend_bytes;
  rsp_bytes_t             full;
  rsp_bytes_t             last_bytes;

  mem_rr_pick #(
    .N  (NUM_CLIENTS),
    .PW (PW)
  ) u_pick (
    .req (client_req),
    .ptr (ptr),
    .gnt (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  assign ptr_nxt = (pick_idx == PW'(NUM_CLIENTS - 1))
                 ? '0 : pick_idx + PW'(1);

  assign sz        = client_size[pick_idx];
  assign sz_up     = {1'b0, sz} + (SIZE_WIDTH + 1)'(LINE_BYTES - 1);
  assign lines_new = CW'(sz_up >> LB);

  // A partial final line reports only its remainder bytes
  assign full       = rsp_bytes_t'(LINE_BYTES);
  assign last_bytes = (tail == '0) ? full : rsp_bytes_t'(tail);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      client_gnt <= '0;
      sram_rd    <= 1'b0;
      sram_addr  <= '0;
      rsp_valid  <= '0;
      rsp_bytes  <= '0;
      rsp_last   <= 1'b0;
      busy       <= 1'b0;
      owner      <= '0;
      cur        <= '0;
      left       <= '0;
      tail       <= '0;
      pend_v     <= 1'b0;
      pend_last  <= 1'b0;
      pend_bytes <= '0;
    end else begin
      client_gnt <= '0;
      sram_rd    <= 1'b0;
      pend_v     <= 1'b0;
      pend_last  <= 1'b0;
      pend_bytes <= '0;
      rsp_valid  <= pend_v ? owner : '0;
      rsp_bytes  <= pend_v ? pend_bytes : '0;
      rsp_last   <= pend_v & pend_last;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (|client_req) begin
            client_gnt <= pick;
            owner      <= pick;
            ptr        <= ptr_nxt;
            cur        <= client_addr[pick_idx];
            left       <= lines_new;
            tail       <= sz[LB-1:0];
            busy       <= 1'b1;
            // Empty transfer: answer straight from DRAIN
            if (sz == '0) begin
              pend_v    <= 1'b1;
              pend_last <= 1'b1;
              state     <= DRAIN;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!sram_busy) begin
            sram_rd   <= 1'b1;
            sram_addr <= cur;
            cur       <= cur + ADDR_WIDTH'(LINE_BYTES);
            left      <= left - CW'(1);
            pend_v    <= 1'b1;
            if (left == CW'(1)) begin
              pend_last  <= 1'b1;
              pend_bytes <= last_bytes;
              state      <= DRAIN;
            end else begin
              pend_bytes <= full;
            end
          end
        end
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
